// File: rtl/core_cache_pkg.sv
// ============================================================================
// core_cache_pkg : shared FSM encoding, cache op codes and default field widths
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

package core_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_RESP = 3'd3,
    ST_WR_REQ  = 3'd4
  } cache_state_t;

  localparam logic CACHE_OP_RD = 1'b0;
  localparam logic CACHE_OP_WR = 1'b1;

  localparam int DEF_OFFSET_AW = 4;
  localparam int DEF_INDEX_AW  = 8;
  localparam int DEF_TAG_WIDTH = 20;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_cache_sb.sv
// ============================================================================
// core_cache_sb : store-buffer FIFO with parallel word-address match and
//                 youngest-match forwarding data. Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module core_cache_sb
  import core_cache_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int SB_DEPTH   = 4,
  localparam int BE_W       = DATA_WIDTH / 8,
  localparam int WORD_LSB   = (BE_W > 1) ? $clog2(BE_W) : 0,
  localparam int CNT_W      = $clog2(SB_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ADDR_WIDTH-1:0]        push_addr,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic [BE_W-1:0]              push_be,
  input  logic                         pop,
  input  logic [ADDR_WIDTH-WORD_LSB-1:0] lookup_word,
  output logic [ADDR_WIDTH-1:0]        head_addr,
  output logic [DATA_WIDTH-1:0]        head_data,
  output logic [BE_W-1:0]              head_be,
  output logic [CNT_W-1:0]             count,
  output logic                         empty,
  output logic                         full,
  output logic                         match_any,
  output logic                         fwd_hit,
  output logic [DATA_WIDTH-1:0]        fwd_data
);

  localparam int PTR_W = clog2_min1(SB_DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem [SB_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [SB_DEPTH];
  logic [BE_W-1:0]       be_mem   [SB_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Physical slot of the entry that is k places behind the head.
  function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= SB_DEPTH) s = s - SB_DEPTH;
    return PTR_W'(s);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(SB_DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign head_be   = be_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
        be_mem[i]   <= '0;
      end
    end else begin
      if (push_ok) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        be_mem[wr_ptr]   <= push_be;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    match_any = 1'b0;
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (k < int'(count) &&
          addr_mem[age_idx(rd_ptr, k)][ADDR_WIDTH-1:WORD_LSB] == lookup_word) begin
        match_any = 1'b1;
        fwd_hit   = &be_mem[age_idx(rd_ptr, k)];
        fwd_data  = data_mem[age_idx(rd_ptr, k)];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_cache_req_buf.sv
// ============================================================================
// core_cache_req_buf : CPU-to-cache request buffer with posted-write SB, read
//                      FSM and RAW hazard check. Option macro: CACHE_BUF_FWD_EN
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module core_cache_req_buf
  import core_cache_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int OFFSET_AW  = DEF_OFFSET_AW,
  parameter  int INDEX_AW   = DEF_INDEX_AW,
  parameter  int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter  int SB_DEPTH   = 4,
  localparam int BE_W       = DATA_WIDTH / 8,
  localparam int CNT_W      = $clog2(SB_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr_i,
  input  logic                  cpu_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] cpu_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
  input  logic [BE_W-1:0]       cpu_wr_en_i,
  output logic [DATA_WIDTH-1:0] cpu_rd_data_o,
  output logic                  cpu_rd_valid_o,
  output logic                  pipeline_stall_o,
  output logic [CNT_W-1:0]      sb_count_o,
  output logic                  cache_req_o,
  output logic                  cache_op_o,
  output logic [INDEX_AW-1:0]   cache_index_o,
  output logic [TAG_WIDTH-1:0]  cache_tag_o,
  output logic [OFFSET_AW-1:0]  cache_offset_o,
  output logic [BE_W-1:0]       cache_wr_en_o,
  output logic [DATA_WIDTH-1:0] cache_wr_data_o,
  input  logic [DATA_WIDTH-1:0] cache_rd_data_i,
  input  logic                  cache_addr_ack_i,
  input  logic                  cache_data_ack_i
);

  localparam int WORD_LSB = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int WORD_W   = ADDR_WIDTH - WORD_LSB;
  localparam int TAG_LSB  = OFFSET_AW + INDEX_AW;

`ifdef CACHE_BUF_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  cache_state_t          state;
  cache_state_t          next_state;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic [ADDR_WIDTH-1:0] sb_head_addr;
  logic [DATA_WIDTH-1:0] sb_head_data;
  logic [BE_W-1:0]       sb_head_be;
  logic [CNT_W-1:0]      sb_count;
  logic                  sb_empty;
  logic                  sb_full;
  logic                  sb_match;
  logic                  sb_fwd_hit;
  logic [DATA_WIDTH-1:0] sb_fwd_data;

  logic                  wr_pop;
  logic                  wr_push;
  logic                  wr_blocked;
  logic [WORD_W-1:0]     rd_word;
  logic                  push_match;
  logic                  hazard;
  logic                  fwd_ok;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  rd_sample;
  logic                  rd_pending;
  logic                  rd_data_take;

  assign wr_pop     = (state == ST_WR_REQ) && cache_addr_ack_i;
  assign wr_push    = cpu_wr_req_i && (!sb_full || wr_pop);
  assign wr_blocked = cpu_wr_req_i && sb_full && !wr_pop;

  // A write pushed this cycle is older than a read sampled this cycle.
  assign rd_word    = cpu_rd_addr_i[ADDR_WIDTH-1:WORD_LSB];
  assign push_match = wr_push && (cpu_wr_addr_i[ADDR_WIDTH-1:WORD_LSB] == rd_word);
  assign hazard     = sb_match || push_match;
  assign fwd_ok     = FWD_EN && (push_match ? (&cpu_wr_en_i) : sb_fwd_hit);
  assign fwd_data   = push_match ? cpu_wr_data_i : sb_fwd_data;

  assign rd_sample    = (state == ST_IDLE) && cpu_rd_req_i;
  assign rd_pending   = cpu_rd_req_i && ((state == ST_IDLE) || (state == ST_WR_REQ));
  assign rd_data_take = ((state == ST_RD_REQ) && cache_addr_ack_i && cache_data_ack_i) ||
                        ((state == ST_RD_WAIT) && cache_data_ack_i);

  core_cache_sb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SB_DEPTH   (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (wr_push),
    .push_addr   (cpu_wr_addr_i),
    .push_data   (cpu_wr_data_i),
    .push_be     (cpu_wr_en_i),
    .pop         (wr_pop),
    .lookup_word (rd_word),
    .head_addr   (sb_head_addr),
    .head_data   (sb_head_data),
    .head_be     (sb_head_be),
    .count       (sb_count),
    .empty       (sb_empty),
    .full        (sb_full),
    .match_any   (sb_match),
    .fwd_hit     (sb_fwd_hit),
    .fwd_data    (sb_fwd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state <= next_state;
      if (rd_sample) rd_addr_q <= cpu_rd_addr_i;
      if (rd_data_take)                        rd_data_q <= cache_rd_data_i;
      else if (rd_sample && hazard && fwd_ok)  rd_data_q <= fwd_data;
    end
  end

  always_comb begin
    next_state      = state;
    cache_req_o     = 1'b0;
    cache_op_o      = CACHE_OP_RD;
    req_addr        = '0;
    cache_wr_en_o   = '0;
    cache_wr_data_o = '0;
    case (state)
      ST_IDLE: begin
        // Reads win over drains unless the read depends on a buffered store.
        if (cpu_rd_req_i) begin
          if (!hazard)        next_state = ST_RD_REQ;
          else if (fwd_ok)    next_state = ST_RD_RESP;
          else if (!sb_empty) next_state = ST_WR_REQ;
        end else if (!sb_empty) begin
          next_state = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        cache_req_o = 1'b1;
        req_addr    = rd_addr_q;
        if (cache_addr_ack_i)
          next_state = cache_data_ack_i ? ST_RD_RESP : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cache_data_ack_i) next_state = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        next_state = ST_IDLE;
      end
      ST_WR_REQ: begin
        cache_req_o     = 1'b1;
        cache_op_o      = CACHE_OP_WR;
        req_addr        = sb_head_addr;
        cache_wr_en_o   = sb_head_be;
        cache_wr_data_o = sb_head_data;
        if (cache_addr_ack_i) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign cache_offset_o   = req_addr[OFFSET_AW-1:0];
  assign cache_index_o    = req_addr[TAG_LSB-1:OFFSET_AW];
  assign cache_tag_o      = req_addr[TAG_LSB+TAG_WIDTH-1:TAG_LSB];
  assign cpu_rd_data_o    = rd_data_q;
  assign cpu_rd_valid_o   = (state == ST_RD_RESP);
  assign sb_count_o       = sb_count;
  assign pipeline_stall_o = rd_pending || (state == ST_RD_REQ) || (state == ST_RD_WAIT) ||
                            wr_blocked;

endmodule

`default_nettype wire

// File: tb/tb_core_cache_req_buf.sv
// ============================================================================
// tb_core_cache_req_buf : table-driven reads plus hand-written write, hazard
//                         and reset sequences with read/write scoreboards
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_core_cache_req_buf;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_rd_req = 1'b0;
  logic [AW-1:0] cpu_rd_addr = '0;
  logic          cpu_wr_req = 1'b0;
  logic [AW-1:0] cpu_wr_addr = '0;
  logic [DW-1:0] cpu_wr_data = '0;
  logic [BW-1:0] cpu_wr_en = '0;
  logic [DW-1:0] cache_rd_data = '0;
  logic          cache_addr_ack = 1'b0;
  logic          cache_data_ack = 1'b0;

  logic [DW-1:0] cpu_rd_data_o;
  logic          cpu_rd_valid_o;
  logic          pipeline_stall_o;
  logic [CW-1:0] sb_count_o;
  logic          cache_req_o;
  logic          cache_op_o;
  logic [7:0]    cache_index_o;
  logic [19:0]   cache_tag_o;
  logic [3:0]    cache_offset_o;
  logic [BW-1:0] cache_wr_en_o;
  logic [DW-1:0] cache_wr_data_o;

  core_cache_req_buf dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_rd_req_i     (cpu_rd_req),
    .cpu_rd_addr_i    (cpu_rd_addr),
    .cpu_wr_req_i     (cpu_wr_req),
    .cpu_wr_addr_i    (cpu_wr_addr),
    .cpu_wr_data_i    (cpu_wr_data),
    .cpu_wr_en_i      (cpu_wr_en),
    .cpu_rd_data_o    (cpu_rd_data_o),
    .cpu_rd_valid_o   (cpu_rd_valid_o),
    .pipeline_stall_o (pipeline_stall_o),
    .sb_count_o       (sb_count_o),
    .cache_req_o      (cache_req_o),
    .cache_op_o       (cache_op_o),
    .cache_index_o    (cache_index_o),
    .cache_tag_o      (cache_tag_o),
    .cache_offset_o   (cache_offset_o),
    .cache_wr_en_o    (cache_wr_en_o),
    .cache_wr_data_o  (cache_wr_data_o),
    .cache_rd_data_i  (cache_rd_data),
    .cache_addr_ack_i (cache_addr_ack),
    .cache_data_ack_i (cache_data_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    int            aack_dly;
    int            dack_dly;
    logic [7:0]    exp_index;
    logic [19:0]   exp_tag;
    logic [3:0]    exp_offset;
  } rd_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } wr_ent_t;

  rd_vec_t       vecs[4];
  logic [DW-1:0] rd_q[$];
  wr_ent_t       wr_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] req_addr();
    return {cache_tag_o, cache_index_o, cache_offset_o};
  endfunction

  // Read scoreboard: every rd_valid pulse consumes the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && cpu_rd_valid_o) begin
      check("rd_valid_expected", 64'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) check("rd_data", cpu_rd_data_o, rd_q.pop_front());
    end
  end

  task automatic run_read(input rd_vec_t v);
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = v.addr;
    #1;
    check("rd_sample_stall", pipeline_stall_o, 1);
    tick();
    for (int c = 0; c < v.aack_dly; c++) begin
      check("rd_req_hold", {cache_req_o, cache_op_o, cache_index_o}, {1'b1, 1'b0, v.exp_index});
      tick();
    end
    check("rd_req", cache_req_o, 1);
    check("rd_op", cache_op_o, 0);
    check("rd_index", cache_index_o, v.exp_index);
    check("rd_tag", cache_tag_o, v.exp_tag);
    check("rd_offset", cache_offset_o, v.exp_offset);
    check("rd_wr_en", cache_wr_en_o, 0);
    cache_addr_ack = 1'b1;
    if (v.dack_dly == 0) begin
      cache_data_ack = 1'b1;
      cache_rd_data  = v.rdata;
      rd_q.push_back(v.rdata);
    end
    tick();
    cache_addr_ack = 1'b0;
    cache_data_ack = 1'b0;
    if (v.dack_dly > 0) begin
      check("rd_wait_req", cache_req_o, 0);
      check("rd_wait_stall", pipeline_stall_o, 1);
      for (int c = 1; c < v.dack_dly; c++) tick();
      cache_data_ack = 1'b1;
      cache_rd_data  = v.rdata;
      rd_q.push_back(v.rdata);
      tick();
      cache_data_ack = 1'b0;
    end
    cache_rd_data = '0;
    check("rd_valid", cpu_rd_valid_o, 1);
    check("rd_resp_stall", pipeline_stall_o, 0);
    cpu_rd_req = 1'b0;
    tick();
    check("rd_valid_pulse", cpu_rd_valid_o, 0);
  endtask

  // Acks every write request and checks it against the write scoreboard.
  task automatic drain_all();
    int guard = 0;
    wr_ent_t e;
    cpu_wr_req = 1'b0;
    while ((wr_q.size() != 0 || sb_count_o != 0) && guard < 100) begin
      cache_addr_ack = 1'b0;
      if (cache_req_o) begin
        check("drain_op", cache_op_o, 1);
        check("drain_expected", 64'(wr_q.size() != 0), 1);
        if (cache_op_o && wr_q.size() != 0) begin
          e = wr_q.pop_front();
          check("drain_addr", req_addr(), e.addr);
          check("drain_data", cache_wr_data_o, e.data);
          check("drain_be", cache_wr_en_o, e.be);
          cache_addr_ack = 1'b1;
        end
      end
      tick();
      guard++;
    end
    cache_addr_ack = 1'b0;
    check("drain_done", 64'(guard < 100), 1);
    check("drain_count", sb_count_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    vecs[0] = '{32'h0000_1234, 32'hDEAD_BEEF, 2, 3, 8'h23, 20'h00001, 4'h4};
    vecs[1] = '{32'hFFFF_FFFC, 32'h1234_5678, 0, 0, 8'hFF, 20'hFFFFF, 4'hC};
    vecs[2] = '{32'h0ABC_DEF8, 32'h0F0F_0F0F, 1, 1, 8'hEF, 20'h0ABCD, 4'h8};
    vecs[3] = '{32'h8000_0000, 32'hCAFE_F00D, 0, 2, 8'h00, 20'h80000, 4'h0};

    repeat (2) @(negedge clk);
    check("reset_req", cache_req_o, 0);
    check("reset_valid", cpu_rd_valid_o, 0);
    check("reset_stall", pipeline_stall_o, 0);
    check("reset_count", sb_count_o, 0);
    check("reset_rdata", cpu_rd_data_o, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_read(vecs[i]);

    // Reset while waiting for read data, with one store buffered.
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 32'h0000_0040;
    tick();
    cache_addr_ack = 1'b1;
    tick();
    cache_addr_ack = 1'b0;
    check("rst_wait_req", cache_req_o, 0);
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 32'h0000_0500;
    cpu_wr_data = 32'h5555_0000;
    cpu_wr_en   = 4'hF;
    tick();
    cpu_wr_req = 1'b0;
    check("rst_pre_count", sb_count_o, 1);
    cpu_rd_req = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("rst_async_count", sb_count_o, 0);
    check("rst_async_stall", pipeline_stall_o, 0);
    tick();
    check("rst_req", cache_req_o, 0);
    check("rst_valid", cpu_rd_valid_o, 0);
    check("rst_rdata", cpu_rd_data_o, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_after_req", cache_req_o, 0);
    check("rst_after_count", sb_count_o, 0);

    // Five writes against a silent cache: the fifth stalls on a full SB.
    for (int i = 0; i < 5; i++) begin
      cpu_wr_req  = 1'b1;
      cpu_wr_addr = 32'h0000_1000 + 32'(i * 4);
      cpu_wr_data = 32'h1111_0000 + 32'(i);
      cpu_wr_en   = (i == 2) ? 4'h3 : 4'hF;
      #1;
      if (i < 4) begin
        check("wr_no_stall", pipeline_stall_o, 0);
        wr_q.push_back('{cpu_wr_addr, cpu_wr_data, cpu_wr_en});
        tick();
      end
    end
    check("full_stall", pipeline_stall_o, 1);
    check("full_count", sb_count_o, 4);
    tick();
    check("full_hold_stall", pipeline_stall_o, 1);
    check("full_hold_count", sb_count_o, 4);
    check("full_head_req", {cache_req_o, cache_op_o}, 2'b11);
    check("full_head_data", cache_wr_data_o, wr_q[0].data);
    cache_addr_ack = 1'b1;
    #1;
    check("full_pop_unstall", pipeline_stall_o, 0);
    void'(wr_q.pop_front());
    wr_q.push_back('{cpu_wr_addr, cpu_wr_data, cpu_wr_en});
    tick();
    cache_addr_ack = 1'b0;
    cpu_wr_req     = 1'b0;
    check("push_pop_count", sb_count_o, 4);
    drain_all();

    // Read-after-write to the same word.
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 32'h0000_0100;
    cpu_wr_data = 32'hA5A5_A5A5;
    cpu_wr_en   = 4'hF;
    tick();
    cpu_wr_req  = 1'b0;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 32'h0000_0100;
    #1;
    check("haz_stall", pipeline_stall_o, 1);
`ifdef CACHE_BUF_FWD_EN
    rd_q.push_back(32'hA5A5_A5A5);
    tick();
    check("fwd_valid", cpu_rd_valid_o, 1);
    check("fwd_no_cache", cache_req_o, 0);
    cpu_rd_req = 1'b0;
    tick();
    wr_q.push_back('{32'h0000_0100, 32'hA5A5_A5A5, 4'hF});
    drain_all();
`else
    tick();
    check("haz_drain_first", {cache_req_o, cache_op_o}, 2'b11);
    check("haz_drain_addr", req_addr(), 32'h0000_0100);
    cache_addr_ack = 1'b1;
    tick();
    cache_addr_ack = 1'b0;
    check("haz_idle_stall", pipeline_stall_o, 1);
    check("haz_sb_empty", sb_count_o, 0);
    tick();
    check("haz_rd_issue", {cache_req_o, cache_op_o}, 2'b10);
    check("haz_rd_addr", req_addr(), 32'h0000_0100);
    cache_addr_ack = 1'b1;
    cache_data_ack = 1'b1;
    cache_rd_data  = 32'hA5A5_A5A5;
    rd_q.push_back(32'hA5A5_A5A5);
    tick();
    cache_addr_ack = 1'b0;
    cache_data_ack = 1'b0;
    check("haz_rd_valid", cpu_rd_valid_o, 1);
    cpu_rd_req = 1'b0;
    tick();
`endif

    // Same-cycle independent read and write: read first, drain after.
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 32'h0000_0200;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 32'h0000_0300;
    cpu_wr_data = 32'h3333_3333;
    cpu_wr_en   = 4'hF;
    #1;
    check("same_stall", pipeline_stall_o, 1);
    wr_q.push_back('{cpu_wr_addr, cpu_wr_data, cpu_wr_en});
    tick();
    cpu_wr_req = 1'b0;
    check("same_count", sb_count_o, 1);
    check("same_rd_first", {cache_req_o, cache_op_o}, 2'b10);
    check("same_rd_addr", req_addr(), 32'h0000_0200);
    cache_addr_ack = 1'b1;
    cache_data_ack = 1'b1;
    cache_rd_data  = 32'h2020_2020;
    rd_q.push_back(32'h2020_2020);
    tick();
    cache_addr_ack = 1'b0;
    cache_data_ack = 1'b0;
    check("same_rd_valid", cpu_rd_valid_o, 1);
    check("same_resp_stall", pipeline_stall_o, 0);
    cpu_rd_req = 1'b0;
    tick();
    drain_all();

    repeat (2) tick();
    check("rd_q_empty", 64'(rd_q.size()), 0);
    check("wr_q_empty", 64'(wr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
